// File: rtl/spi_reg_bridge.sv
// Byte-stream command decoder between the SPI slave byte engine and the register bus:
// framed read/write bursts with address auto-increment, bus timeout, overrun and abort handling.
module spi_reg_bridge #(
  parameter int ADDR_WIDTH     = 7,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_busy,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_reg_req,
  output logic                  o_reg_we,
  output logic [ADDR_WIDTH-1:0] o_reg_addr,
  output logic [7:0]            o_reg_wdata,
  input  logic [7:0]            i_reg_rdata,
  input  logic                  i_reg_ack,
  output logic                  o_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_WR_WAIT = 3'd2,
    S_WR_BUS  = 3'd3,
    S_RD_BUS  = 3'd4,
    S_RD_WAIT = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  localparam logic [7:0] TMO_LIMIT   = 8'(TIMEOUT_CYCLES);
  localparam logic [7:0] RD_TMO_DATA = 8'hEE;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            cnt_q;
  logic [7:0]            tmo_q;
  logic [7:0]            tx_data_q;
  logic [7:0]            wdata_q;
  logic                  tx_valid_q;
  logic                  req_q;
  logic                  we_q;
  logic                  err_q;
  logic                  ovr_q;

  logic [ADDR_WIDTH-1:0] addr_d;
  logic [7:0]            cnt_d;
  logic [8:0]            tmo_d;
  logic                  bus_ack_d;
  logic                  bus_tmo_d;
  logic                  bus_done_d;

  // Incremented address/count/timer values and bus completion qualifiers.
  always_comb begin
    addr_d     = addr_q + ADDR_WIDTH'(1);
    cnt_d      = cnt_q - 8'd1;
    tmo_d      = {1'b0, tmo_q} + 9'd1;
    bus_ack_d  = req_q & i_reg_ack;
    bus_tmo_d  = req_q & ~i_reg_ack & (tmo_d == {1'b0, TMO_LIMIT});
    bus_done_d = bus_ack_d | bus_tmo_d;
  end

  // Frame decoder FSM, bus handshake and every registered output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      cnt_q      <= 8'd0;
      tmo_q      <= 8'd0;
      tx_data_q  <= 8'd0;
      wdata_q    <= 8'd0;
      tx_valid_q <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if (req_q && !bus_done_d) begin
        tmo_q <= tmo_d[7:0];
      end
      if ((state_q != S_IDLE) && !i_busy) begin
        // CS released mid-frame: abandon everything; a late ack finds req low and is ignored.
        state_q <= S_IDLE;
        req_q   <= 1'b0;
        ovr_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (i_rx_valid && i_busy) begin
              we_q    <= ~i_rx_data[7];
              addr_q  <= i_rx_data[ADDR_WIDTH-1:0];
              ovr_q   <= 1'b0;
              state_q <= S_LEN;
            end
          end
          S_LEN: begin
            if (i_rx_valid) begin
              cnt_q <= i_rx_data;
              if (i_rx_data == 8'd0) begin
                state_q <= S_DRAIN;
              end else if (we_q) begin
                state_q <= S_WR_WAIT;
              end else begin
                req_q   <= 1'b1;
                tmo_q   <= 8'd0;
                state_q <= S_RD_BUS;
              end
            end
          end
          S_WR_WAIT: begin
            if (i_rx_valid) begin
              wdata_q <= i_rx_data;
              req_q   <= 1'b1;
              tmo_q   <= 8'd0;
              state_q <= S_WR_BUS;
            end
          end
          S_WR_BUS: begin
            if (i_rx_valid) begin
              ovr_q <= 1'b1;
              err_q <= 1'b1;
            end
            if (bus_done_d) begin
              req_q  <= 1'b0;
              addr_q <= addr_d;
              cnt_q  <= cnt_d;
              if (bus_tmo_d) begin
                err_q <= 1'b1;
              end
              if (ovr_q || i_rx_valid || (cnt_d == 8'd0)) begin
                state_q <= S_DRAIN;
              end else begin
                state_q <= S_WR_WAIT;
              end
            end
          end
          S_RD_BUS: begin
            if (i_rx_valid) begin
              ovr_q <= 1'b1;
              err_q <= 1'b1;
            end
            if (bus_done_d) begin
              req_q      <= 1'b0;
              tx_valid_q <= 1'b1;
              if (bus_ack_d) begin
                tx_data_q <= i_reg_rdata;
              end else begin
                tx_data_q <= RD_TMO_DATA;
                err_q     <= 1'b1;
              end
              if (ovr_q || i_rx_valid) begin
                state_q <= S_DRAIN;
              end else begin
                state_q <= S_RD_WAIT;
              end
            end
          end
          S_RD_WAIT: begin
            // Each dummy byte shifts out the preloaded data, so fetch the next register now.
            if (i_rx_valid) begin
              addr_q <= addr_d;
              cnt_q  <= cnt_d;
              if (cnt_d != 8'd0) begin
                req_q   <= 1'b1;
                tmo_q   <= 8'd0;
                state_q <= S_RD_BUS;
              end else begin
                state_q <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            state_q <= S_DRAIN;
          end
          default: begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_reg_req   = req_q;
  assign o_reg_we    = we_q;
  assign o_reg_addr  = addr_q;
  assign o_reg_wdata = wdata_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: directed protocol scenarios plus random frames scored
// against a frame-level model with its own register image.
module tb_spi_reg_bridge;

  localparam int TMO = 4;
  localparam int GAP = 8;
  localparam int D   = 1024;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       i_busy;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       o_reg_req;
  logic       o_reg_we;
  logic [6:0] o_reg_addr;
  logic [7:0] o_reg_wdata;
  logic [7:0] i_reg_rdata;
  logic       i_reg_ack;
  logic       o_err;

  spi_reg_bridge #(.ADDR_WIDTH(7), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_busy(i_busy), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
    .o_reg_req(o_reg_req), .o_reg_we(o_reg_we), .o_reg_addr(o_reg_addr),
    .o_reg_wdata(o_reg_wdata), .i_reg_rdata(i_reg_rdata), .i_reg_ack(i_reg_ack),
    .o_err(o_err)
  );

  int         n_checks;
  int         n_fail;
  logic [7:0] mmem [128];
  logic [7:0] fdata [256];
  int         lat_arr [D];
  int         inj_req;

  logic [7:0] smem [128];
  int         acc_idx;
  int         inj_done;

  logic       obs_we [D];
  logic [6:0] obs_addr [D];
  logic [7:0] obs_wd [D];
  logic [7:0] obs_tx [D];
  int         obs_n;
  int         obs_tx_n;
  int         err_n;
  int         viol_n;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    tick();
    i_rx_valid = 1'b0;
    repeat (GAP) tick();
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({o_tx_data, o_tx_valid, o_reg_req, o_reg_we, o_reg_addr, o_reg_wdata, o_err});
  endfunction

  // Register slave: per-access ack latency from lat_arr; latency >= TMO never acks in time.
  initial begin
    logic sprev;
    int   sn;
    int   slat;
    i_reg_ack   = 1'b0;
    i_reg_rdata = 8'd0;
    acc_idx     = 0;
    inj_done    = 0;
    sprev       = 1'b0;
    sn          = 0;
    slat        = 0;
    for (int i = 0; i < 128; i++) smem[i] = 8'(i + 64);
    forever begin
      tick();
      i_reg_ack = 1'b0;
      if (o_reg_req) begin
        if (!sprev) begin
          sn   = 0;
          slat = lat_arr[acc_idx % D];
          acc_idx++;
        end else begin
          sn++;
        end
        i_reg_rdata = smem[o_reg_addr];
        if (sn == slat) begin
          i_reg_ack = 1'b1;
          if (o_reg_we) smem[o_reg_addr] = o_reg_wdata;
        end
      end else if (inj_req != inj_done) begin
        i_reg_ack = 1'b1;
        inj_done++;
      end
      sprev = o_reg_req;
    end
  end

  // Passive monitor: records bus accesses, tx bytes, error pulses and protocol violations.
  initial begin
    logic        pr;
    logic        ptx;
    logic [15:0] hold;
    obs_n = 0; obs_tx_n = 0; err_n = 0; viol_n = 0;
    pr = 1'b0; ptx = 1'b0; hold = 16'd0;
    forever begin
      @(negedge i_clk);
      if (o_reg_req && !pr) begin
        obs_we[obs_n % D]   = o_reg_we;
        obs_addr[obs_n % D] = o_reg_addr;
        obs_wd[obs_n % D]   = o_reg_wdata;
        obs_n++;
      end
      if (o_reg_req && pr && ({o_reg_we, o_reg_addr, o_reg_wdata} != hold)) viol_n++;
      if (o_tx_valid) begin
        obs_tx[obs_tx_n % D] = o_tx_data;
        obs_tx_n++;
        if (ptx) viol_n++;
      end
      if (o_err) err_n++;
      pr   = o_reg_req;
      ptx  = o_tx_valid;
      hold = {o_reg_we, o_reg_addr, o_reg_wdata};
    end
  end

  // One complete frame: model predicts accesses, tx bytes and errors from the frame rules.
  task automatic run_frame(input logic [7:0] cmd, input int len, input int max_lat);
    int         lats [256];
    logic [6:0] e_addr [256];
    logic [7:0] e_tx [256];
    int         e_tx_n, e_err, acc0, tx0, err0, viol0;
    logic       rd;
    logic [6:0] a;
    rd = cmd[7];
    a  = cmd[6:0];
    acc0 = obs_n; tx0 = obs_tx_n; err0 = err_n; viol0 = viol_n;
    e_tx_n = 0; e_err = 0;
    for (int k = 0; k < len; k++) begin
      lats[k] = (max_lat == 0) ? 0 : int'($urandom_range(0, max_lat));
      lat_arr[(acc_idx + k) % D] = lats[k];
      e_addr[k] = a;
      if (lats[k] >= TMO) e_err++;
      if (rd) begin
        e_tx[e_tx_n] = (lats[k] >= TMO) ? 8'hEE : mmem[a];
        e_tx_n++;
      end else if (lats[k] < TMO) begin
        mmem[a] = fdata[k];
      end
      a = a + 7'd1;
    end
    i_busy = 1'b1;
    tick();
    for (int j = 0; j < len + 2; j++) begin
      int acc;
      acc = -1;
      if (!rd && j >= 2) acc = j - 2;
      else if (rd && j == 1 && len > 0) acc = 0;
      else if (rd && j >= 2 && (j - 2) < (len - 1)) acc = j - 1;
      if (j == 0) i_rx_data = cmd;
      else if (j == 1) i_rx_data = 8'(len);
      else i_rx_data = fdata[j - 2];
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
      if (acc >= 0) begin
        check_eq("req_next_cycle", 32'(o_reg_req), 32'd1);
        if (lats[acc] == 0) begin
          tick();
          check_eq("zero_wait_req_low", 32'(o_reg_req), 32'd0);
          if (rd) check_eq("zero_wait_tx_valid", 32'(o_tx_valid), 32'd1);
          repeat (GAP - 1) tick();
        end else begin
          repeat (GAP) tick();
        end
      end else begin
        repeat (GAP) tick();
      end
    end
    i_busy = 1'b0;
    repeat (3) tick();
    check_eq("acc_count", 32'(obs_n - acc0), 32'(len));
    for (int k = 0; k < len && (acc0 + k) < obs_n; k++) begin
      check_eq("acc_we", 32'(obs_we[(acc0 + k) % D]), 32'(!rd));
      check_eq("acc_addr", 32'(obs_addr[(acc0 + k) % D]), 32'(e_addr[k]));
      if (!rd) check_eq("acc_wdata", 32'(obs_wd[(acc0 + k) % D]), 32'(fdata[k]));
    end
    check_eq("tx_count", 32'(obs_tx_n - tx0), 32'(e_tx_n));
    for (int k = 0; k < e_tx_n && (tx0 + k) < obs_tx_n; k++) begin
      check_eq("tx_data", 32'(obs_tx[(tx0 + k) % D]), 32'(e_tx[k]));
    end
    check_eq("err_count", 32'(err_n - err0), 32'(e_err));
    check_eq("protocol_viol", 32'(viol_n - viol0), 32'd0);
  endtask

  initial begin
    int b_acc, b_tx, b_err, n;
    n_checks = 0; n_fail = 0; inj_req = 0;
    i_rst = 1'b1; i_busy = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'd0;
    for (int i = 0; i < 128; i++) mmem[i] = 8'(i + 64);
    for (int i = 0; i < D; i++) lat_arr[i] = 0;
    for (int i = 0; i < 256; i++) fdata[i] = 8'd0;
    repeat (3) tick();
    check_eq("reset_outputs", all_outs(), 32'd0);
    i_rst = 1'b0;
    tick();
    check_eq("idle_outputs", all_outs(), 32'd0);

    // Write burst, zero-wait slave.
    fdata[0] = 8'hA1; fdata[1] = 8'hA2; fdata[2] = 8'hA3;
    b_acc = obs_n; b_err = err_n;
    run_frame(8'h10, 3, 0);
    for (int k = 0; k < 3; k++) begin
      check_eq("wr_burst_addr", 32'(obs_addr[(b_acc + k) % D]), 32'(8'h10 + k));
      check_eq("wr_burst_data", 32'(obs_wd[(b_acc + k) % D]), 32'(8'hA1 + k));
    end
    check_eq("wr_burst_no_err", 32'(err_n - b_err), 32'd0);

    // Read burst wrapping 0x7E -> 0x00.
    fdata[0] = 8'h00; fdata[1] = 8'h00; fdata[2] = 8'h00;
    b_tx = obs_tx_n;
    run_frame(8'hFE, 3, 0);
    check_eq("rd_wrap_0", 32'(obs_tx[b_tx % D]), 32'h0BE);
    check_eq("rd_wrap_1", 32'(obs_tx[(b_tx + 1) % D]), 32'h0BF);
    check_eq("rd_wrap_2", 32'(obs_tx[(b_tx + 2) % D]), 32'h040);

    // Read timeout.
    lat_arr[acc_idx % D] = 99;
    b_err = err_n;
    i_busy = 1'b1; tick();
    send_byte(8'h85);
    i_rx_data = 8'h01; i_rx_valid = 1'b1; tick(); i_rx_valid = 1'b0;
    n = 0;
    while (o_reg_req && n < 20) begin
      n++;
      tick();
    end
    check_eq("tmo_req_cycles", 32'(n), 32'(TMO));
    check_eq("tmo_err_pulse", 32'(o_err), 32'd1);
    check_eq("tmo_tx_valid", 32'(o_tx_valid), 32'd1);
    check_eq("tmo_tx_data", 32'(o_tx_data), 32'h0EE);
    repeat (GAP) tick();
    send_byte(8'h00);
    i_busy = 1'b0; repeat (3) tick();
    check_eq("tmo_err_total", 32'(err_n - b_err), 32'd1);

    // Overrun during a slow write.
    lat_arr[acc_idx % D] = 3;
    b_acc = obs_n; b_err = err_n;
    i_busy = 1'b1; tick();
    send_byte(8'h30);
    send_byte(8'h03);
    i_rx_data = 8'h11; i_rx_valid = 1'b1; tick(); i_rx_valid = 1'b0;
    check_eq("ovr_req", 32'(o_reg_req), 32'd1);
    tick();
    i_rx_data = 8'h22; i_rx_valid = 1'b1; tick(); i_rx_valid = 1'b0;
    check_eq("ovr_err_pulse", 32'(o_err), 32'd1);
    repeat (GAP) tick();
    send_byte(8'h33);
    i_busy = 1'b0; repeat (3) tick();
    mmem[7'h30] = 8'h11;
    check_eq("ovr_one_write", 32'(obs_n - b_acc), 32'd1);
    check_eq("ovr_addr", 32'(obs_addr[b_acc % D]), 32'h30);
    check_eq("ovr_wdata", 32'(obs_wd[b_acc % D]), 32'h11);
    check_eq("ovr_err_total", 32'(err_n - b_err), 32'd1);

    // Abort in WR_BUS, late ack, then a fresh frame.
    lat_arr[acc_idx % D] = 99;
    b_acc = obs_n; b_err = err_n;
    i_busy = 1'b1; tick();
    send_byte(8'h40);
    send_byte(8'h02);
    i_rx_data = 8'h55; i_rx_valid = 1'b1; tick(); i_rx_valid = 1'b0;
    check_eq("abort_req_high", 32'(o_reg_req), 32'd1);
    i_busy = 1'b0; tick();
    check_eq("abort_req_drop", 32'(o_reg_req), 32'd0);
    inj_req++;
    repeat (4) tick();
    check_eq("abort_no_err", 32'(err_n - b_err), 32'd0);
    check_eq("abort_acc", 32'(obs_n - b_acc), 32'd1);
    fdata[0] = 8'h77;
    b_acc = obs_n;
    run_frame(8'h05, 1, 0);
    check_eq("post_abort_addr", 32'(obs_addr[b_acc % D]), 32'h05);
    check_eq("post_abort_data", 32'(obs_wd[b_acc % D]), 32'h77);

    // Zero-length frame.
    run_frame(8'h20, 0, 0);

    // Reset while a read is outstanding.
    lat_arr[acc_idx % D] = 99;
    i_busy = 1'b1; tick();
    send_byte(8'h81);
    i_rx_data = 8'h01; i_rx_valid = 1'b1; tick(); i_rx_valid = 1'b0;
    check_eq("rst_rd_req", 32'(o_reg_req), 32'd1);
    i_rst = 1'b1; tick();
    check_eq("rst_mid_access", all_outs(), 32'd0);
    i_rst = 1'b0; i_busy = 1'b0;
    repeat (3) tick();

    // Random frames, random slave latency including timeouts.
    for (int f = 0; f < 30; f++) begin
      logic [7:0] cmd;
      int         len;
      cmd = 8'($urandom);
      len = int'($urandom_range(0, 6));
      for (int k = 0; k < len; k++) fdata[k] = 8'($urandom);
      run_frame(cmd, len, 5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Byte-level command decoder that sits directly downstream of the SPI slave byte engine in the flight-controller SPI path. It consumes received bytes, with the slave's busy flag as frame delimiter, and turns framed commands into single-beat register-bus reads and writes with address auto-increment. Read data goes back to the SPI slave as transmit bytes. The bridge enforces frame boundaries, bus timeouts and overrun detection so a misbehaving host cannot hang the register bus.

## Interface
- ADDR_WIDTH, 7, register address width (1..7); the address is taken from command bits [ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 255, maximum number of i_clk cycles o_reg_req may stay high without i_reg_ack (≥1, 8-bit counter).

- i_clk  in  1  system clock; the only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte from the SPI slave.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid.
- i_busy  in  1  SPI frame active (CS asserted); low = no frame.
- o_tx_data  out  8  byte for the SPI slave to transmit.
- o_tx_valid  out  1  one-cycle load strobe for o_tx_data.
- o_reg_req  out  1  bus request, held until ack or timeout.
- o_reg_we  out  1  1 = write, 0 = read; stable while o_reg_req is high.
- o_reg_addr  out  ADDR_WIDTH  bus address; stable while o_reg_req is high.
- o_reg_wdata  out  8  write data; stable while o_reg_req is high.
- i_reg_rdata  in  8  read data, sampled in the i_reg_ack cycle.
- i_reg_ack  in  1  one-cycle completion strobe.
- o_err  out  1  one-cycle pulse on timeout or overrun.

## Operation
- Frame format: command byte (bit7 = 1 read / 0 write; low bits = start address), then length byte N (0..255), then N data bytes. For reads the N data bytes are dummy bytes sent by the host.
- States:
  - IDLE: wait for the command byte. Latch the address and direction, then go to LEN.
  - LEN: wait for the length byte. If N = 0, go to DRAIN. Write: go to WR_WAIT. Read: issue a request and go to RD_BUS.
  - WR_WAIT: a data byte drives o_reg_wdata and a request; go to WR_BUS.
  - WR_BUS: on ack or timeout, increment the address and decrement the remaining count. Go to DRAIN if the count reaches 0, otherwise back to WR_WAIT.
  - RD_BUS: on ack, capture i_reg_rdata; on timeout, use 8'hEE. Pulse o_tx_valid with that byte and go to RD_WAIT.
  - RD_WAIT: each received dummy byte increments the address and decrements the count. If the count is still nonzero, issue the next request and go to RD_BUS; otherwise go to DRAIN.
  - DRAIN: ignore received bytes until i_busy falls.
- Read pipelining: data for register addr+k is loaded into the slave before dummy byte k is clocked out. The host must leave at least the bus latency plus 3 cycles between bytes.
- Address arithmetic: increment modulo 2^ADDR_WIDTH, so 7'h7F wraps to 7'h00. The remaining count is 8 bits and never underflows.
- Overrun: an i_rx_valid arriving in WR_BUS or RD_BUS drops the byte, pulses o_err, lets the pending access complete, then goes to DRAIN.
- Timeout: the counter clears whenever o_reg_req rises. When it equals TIMEOUT_CYCLES, o_reg_req drops and o_err pulses.
  - A write timeout counts as completed.
  - A read timeout returns 8'hEE.
- Frame abort: i_busy low in any state except IDLE forces IDLE on the next cycle and drops o_reg_req immediately. A late i_reg_ack arriving after the abort is ignored. i_busy low has priority over a coincident i_rx_valid, and that byte is discarded.

## Timing
- Reset values:
  - o_tx_data = 0, o_tx_valid = 0
  - o_reg_req = 0, o_reg_we = 0, o_reg_addr = 0, o_reg_wdata = 0
  - o_err = 0
  - state = IDLE, counters = 0
- i_rx_valid in cycle t → o_reg_req high in cycle t+1, with addr, we and wdata valid in the same cycle.
- i_reg_ack in cycle t → o_reg_req low in t+1. For reads, o_tx_valid is high in t+1 with the data; o_tx_valid is always exactly one cycle wide.
- A zero-wait slave (ack in the first req cycle) therefore completes an access in 2 cycles.
- o_err is registered: it is high the cycle after the triggering event.
- i_rst mid-access drops o_reg_req on the next edge and returns to IDLE.

## Test plan
- Write burst: bytes 0x10, 0x03, 0xA1, 0xA2, 0xA3 with zero-wait acks → writes 0xA1, 0xA2, 0xA3 to addresses 0x10, 0x11, 0x12; o_err never pulses.
- Read burst with wrap: bytes 0xFE, 0x03, then dummies, with the slave returning addr+0x40 → o_tx_data sequence 0xBE, 0xBF, 0x40 (addresses 0x7E, 0x7F, 0x00).
- Timeout: read with i_reg_ack held low and TIMEOUT_CYCLES = 4 → o_reg_req high for exactly 4 cycles, then o_err pulse, then o_tx_valid with 0xEE.
- Overrun: write with ack delayed 20 cycles and the next byte arriving at cycle 5 → one write only, o_err pulse, later bytes ignored until i_busy falls.
- Abort: i_busy drops while in WR_BUS → o_reg_req low next cycle, state IDLE. A late ack is ignored, and a new frame 0x05, 0x01, 0x77 writes 0x77 to 0x05.
- Length zero plus reset: 0x20, 0x00 → no request issued. Asserting i_rst during RD_BUS clears every output to 0 on the next cycle.
